// File: rtl/cnn_pkg.sv
// Shared constants and FSM state type for the CNN result path.
// Imported by the row buffer and the result reader.
package cnn_pkg;

    localparam int CNN_DATA_W = 13;
    localparam int CNN_LANES  = 5;

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

endpackage

// File: rtl/cnn_row_buffer.sv
// Row storage for captured CNN result rows.
// One write port, one combinational row read port.
module cnn_row_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int LANES  = CNN_LANES,
    parameter int DEPTH  = 5,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr_en,
    input  logic [AW-1:0]             i_wr_idx,
    input  logic [LANES*DATA_W-1:0]   i_wr_data,
    input  logic [AW-1:0]             i_rd_idx,
    output logic [LANES*DATA_W-1:0]   o_rd_data
);

    logic [LANES*DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/cnn_result_reader.sv
// Captures parallel CNN result rows and drains them as a
// serial valid/ready stream, one element per handshake.
module cnn_result_reader
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int LANES  = CNN_LANES,
    parameter int DEPTH  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    in_done,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CW-1:0]           r_row_cnt;
    logic [AW-1:0]           r_row_idx;
    logic [LW-1:0]           r_lane_idx;
    logic                    r_valid;
    logic                    r_overflow;

    logic                    w_cap;
    logic [CW-1:0]           w_rows_next;
    logic                    w_fill_done;
    logic                    w_hs;
    logic                    w_is_last;
    logic [LANES*DATA_W-1:0] w_row;
    logic [DATA_W-1:0]       w_elem;

    cnn_row_buffer #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_cap),
        .i_wr_idx  (r_row_cnt[AW-1:0]),
        .i_wr_data (in_data),
        .i_rd_idx  (r_row_idx),
        .o_rd_data (w_row)
    );

    assign w_cap       = in_valid && (r_state == FILL);
    assign w_rows_next = r_row_cnt + CW'(w_cap);
    assign w_fill_done = (in_done && (w_rows_next != '0))
                      || (w_cap && (w_rows_next == DEPTH_C));
    assign w_hs        = r_valid && out_ready;
    assign w_is_last   = (CW'(r_row_idx) == r_row_cnt - CW'(1))
                      && (r_lane_idx == LANE_LAST);

    always_comb begin
        w_elem = '0;
        for (int l = 0; l < LANES; l++) begin
            if (r_lane_idx == LW'(l)) begin
                w_elem = w_row[l*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            FILL:  if (w_fill_done) w_state_next = DRAIN;
            DRAIN: if (w_hs && w_is_last) w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    // The buffer is frozen in DRAIN, so indices alone keep the output stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_cnt  <= '0;
            r_row_idx  <= '0;
            r_lane_idx <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (in_valid && (r_state == DRAIN)) begin
                r_overflow <= 1'b1;
            end
            if (w_cap) begin
                r_row_cnt <= w_rows_next;
            end
            if (r_state == DRAIN) begin
                if (!r_valid) begin
                    r_valid <= 1'b1;
                end else if (out_ready) begin
                    if (w_is_last) begin
                        r_valid    <= 1'b0;
                        r_row_cnt  <= '0;
                        r_row_idx  <= '0;
                        r_lane_idx <= '0;
                    end else if (r_lane_idx == LANE_LAST) begin
                        r_lane_idx <= '0;
                        r_row_idx  <= r_row_idx + AW'(1);
                    end else begin
                        r_lane_idx <= r_lane_idx + LW'(1);
                    end
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_valid ? w_elem : '0;
    assign out_last  = r_valid && w_is_last;
    assign busy      = (r_state == DRAIN);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cnn_result_reader.sv
// Scoreboard bench for cnn_result_reader: frame model feeds an
// expected-element queue, a negedge monitor pops on each handshake.
module tb_cnn_result_reader;

    localparam int DW    = 13;
    localparam int LN    = 5;
    localparam int DP    = 5;
    localparam int RW    = LN * DW;

    logic          clk;
    logic          rst;
    logic [RW-1:0] in_data;
    logic          in_valid;
    logic          in_done;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          overflow;

    cnn_result_reader #(
        .DATA_W (DW),
        .LANES  (LN),
        .DEPTH  (DP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_done   (in_done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int pops  = 0;

    logic [RW-1:0] rows_m [$];
    logic [DW:0]   exp_q  [$];

    bit            rnd_ready = 0;
    bit            stalled   = 0;
    bit            chk_idle  = 0;
    logic [DW-1:0] hold_d;
    logic          hold_l;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: a drained frame is every held row, lane 0 first.
    task automatic flush_model();
        int nr;
        nr = rows_m.size();
        for (int r = 0; r < nr; r++) begin
            for (int l = 0; l < LN; l++) begin
                exp_q.push_back({(r == nr - 1) && (l == LN - 1),
                                 rows_m[r][l*DW +: DW]});
            end
        end
        rows_m.delete();
    endtask

    function automatic logic [RW-1:0] pat_row(input int r);
        logic [RW-1:0] v;
        for (int l = 0; l < LN; l++) v[l*DW +: DW] = DW'(16 * r + l);
        return v;
    endfunction

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] v;
        for (int l = 0; l < LN; l++) v[l*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (chk_idle) begin
                chk("idle_after_last", {30'd0, busy, out_valid}, 0);
                chk_idle = 0;
            end
            if (out_valid) begin
                if (stalled) begin
                    chk("hold_data", 32'(out_data), 32'(hold_d));
                    chk("hold_last", 32'(out_last), 32'(hold_l));
                end
                if (out_ready) begin
                    stalled = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        logic [DW:0] e;
                        e = exp_q.pop_front();
                        chk("elem_data", 32'(out_data), 32'(e[DW-1:0]));
                        chk("elem_last", 32'(out_last), 32'(e[DW]));
                        pops++;
                        if (e[DW]) chk_idle = 1;
                    end
                end else begin
                    stalled = 1;
                    hold_d  = out_data;
                    hold_l  = out_last;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_start();
        @(negedge clk);
        chk("start_busy", 32'(busy), 1);
        chk("start_valid_low", 32'(out_valid), 0);
        @(negedge clk);
        chk("start_valid_high", 32'(out_valid), 1);
        cycle();
    endtask

    task automatic push_row(input logic [RW-1:0] d, input bit done);
        bit trig;
        in_valid = 1'b1;
        in_data  = d;
        in_done  = done;
        rows_m.push_back(d);
        trig = done || (rows_m.size() == DP);
        if (trig) flush_model();
        cycle();
        in_valid = 1'b0;
        in_done  = 1'b0;
        if (trig) check_start();
    endtask

    task automatic push_done();
        bit trig;
        in_done = 1'b1;
        trig = (rows_m.size() > 0);
        if (trig) flush_model();
        cycle();
        in_done = 1'b0;
        if (trig) check_start();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        chk("drain_complete", 32'(ok), 1);
        exp_q.delete();
        cycle();
        cycle();
    endtask

    initial begin
        int base;
        bit got;
        rst      = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_done  = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();

        // three rows then a separate done pulse
        for (int r = 0; r < 3; r++) push_row(pat_row(r), 1'b0);
        chk("fill_not_busy", 32'(busy), 0);
        push_done();
        wait_idle();

        // five rows, auto drain
        for (int r = 0; r < 5; r++) push_row(pat_row(r), 1'b0);
        wait_idle();

        // random backpressure on a 2-row frame
        rnd_ready = 1;
        push_row(rnd_row(), 1'b0);
        push_row(rnd_row(), 1'b1);
        wait_idle();

        // row and done arriving during drain are dropped
        chk("ovf_before", 32'(overflow), 0);
        push_row(rnd_row(), 1'b0);
        push_row(rnd_row(), 1'b0);
        push_done();
        in_valid = 1'b1;
        in_done  = 1'b1;
        in_data  = rnd_row();
        cycle();
        in_valid = 1'b0;
        in_done  = 1'b0;
        @(negedge clk);
        chk("ovf_set", 32'(overflow), 1);
        wait_idle();
        chk("ovf_sticky", 32'(overflow), 1);

        // done with nothing held
        rnd_ready = 0;
        in_done = 1'b1;
        cycle();
        in_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("empty_done_valid", 32'(out_valid), 0);
            chk("empty_done_busy", 32'(busy), 0);
        end
        cycle();
        push_row(pat_row(7), 1'b1);
        wait_idle();

        // random frames
        rnd_ready = 1;
        for (int f = 0; f < 6; f++) begin
            int nr;
            nr = $urandom_range(1, DP);
            for (int r = 0; r < nr; r++)
                push_row(rnd_row(), (r == nr - 1) && ($urandom_range(0, 1) == 1 || nr < DP));
            wait_idle();
        end

        // reset in the middle of a drain
        rnd_ready = 0;
        base = pops;
        for (int r = 0; r < 3; r++) push_row(pat_row(r), 1'b0);
        push_done();
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (pops >= base + 3) begin
                got = 1;
                break;
            end
        end
        chk("reset_wait_3", 32'(got), 1);
        cycle();
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_data", 32'(out_data), 0);
        chk("midrst_last", 32'(out_last), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        exp_q.delete();
        rows_m.delete();
        stalled  = 0;
        chk_idle = 0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        base = pops;
        push_row(pat_row(2), 1'b1);
        wait_idle();
        chk("post_rst_count", 32'(pops - base), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
